// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_ctrl : direct-mapped, write-back, write-allocate L1 data cache control
// Revision    : 1.0
// ============================================================================
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int LINE_BITS  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - INDEX_BITS - 5;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WRITEBACK   = 2'd1,
    S_ALLOCATE    = 2'd2,
    S_REFILL_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LINE_BITS-1:0] data_q [LINES];
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [2:0]            word;
  logic [7:0]            word_lsb;
  logic                  req;
  logic                  hit;
  logic                  victim_dirty;
  logic [LINE_BITS-1:0]  line;
  logic                  wr_hit;
  logic                  refill;
  logic                  unused_addr_lsbs;

  assign idx              = cpu_addr_i[INDEX_BITS+4:5];
  assign tag              = cpu_addr_i[31:INDEX_BITS+5];
  assign word             = cpu_addr_i[4:2];
  assign word_lsb         = {word, 5'b00000};
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];
  assign req              = cpu_MemRead_i | cpu_MemWrite_i;
  assign line             = data_q[idx];
  assign hit              = req & valid_q[idx] & (tag_q[idx] == tag);
  assign victim_dirty     = valid_q[idx] & dirty_q[idx];

  always_comb begin
    state_d      = state_q;
    cpu_stall_o  = 1'b0;
    cpu_data_o   = '0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    wr_hit       = 1'b0;
    refill       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read+write request is a store, so no load data.
            if (cpu_MemWrite_i) wr_hit = 1'b1;
            else                cpu_data_o = line[word_lsb +: 32];
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b00000};
        mem_data_o   = line;
        if (mem_ack_i) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, 5'b00000};
        if (mem_ack_i) begin
          refill  = 1'b1;
          state_d = S_REFILL_DONE;
        end
      end
      S_REFILL_DONE: begin
        cpu_stall_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag/data storage is never cleared; the valid bits alone qualify it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill) begin
        data_q[idx] <= mem_data_i;
        tag_q[idx]  <= tag;
      end else if (wr_hit) begin
        data_q[idx][word_lsb +: 32] <= cpu_data_i;
      end
    end
  end

endmodule
`default_nettype wire
